// File: rtl/fifo_rd_packer_if.sv
// Handshake bundle for fifo_rd_packer: FIFO read port on one side, packed valid/ready stream on the other.
// master = packer view, slave = FIFO/downstream view.
interface fifo_rd_packer_if #(
   parameter int unsigned IN_WIDTH = 8,
   parameter int unsigned RATIO    = 4
);
   localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;

   logic                 fifo_ren;
   logic [IN_WIDTH-1:0]  fifo_rdata;
   logic                 fifo_empty;
   logic                 flush;
   logic                 m_valid;
   logic                 m_ready;
   logic [OUT_WIDTH-1:0] m_data;
   logic [RATIO-1:0]     m_keep;
   logic                 m_last;

   modport master (
      output fifo_ren,
      input  fifo_rdata,
      input  fifo_empty,
      input  flush,
      output m_valid,
      input  m_ready,
      output m_data,
      output m_keep,
      output m_last
   );

   modport slave (
      input  fifo_ren,
      output fifo_rdata,
      output fifo_empty,
      output flush,
      input  m_valid,
      output m_ready,
      input  m_data,
      input  m_keep,
      input  m_last
   );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops RATIO show-ahead FIFO entries into one wide word behind a one-word valid/ready output register.
// Optional idle auto-flush is enabled by defining PACKER_TIMEOUT_EN.
module fifo_rd_packer #(
   parameter int unsigned IN_WIDTH  = 8,
   parameter int unsigned RATIO     = 4,
   parameter int unsigned OUT_WIDTH = IN_WIDTH * RATIO,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic               clk,
   input  logic               rst,
   fifo_rd_packer_if.master   bus
);
   localparam int unsigned IDX_W  = $clog2(RATIO + 1);
   localparam int unsigned LANE_W = $clog2(RATIO);
   localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(RATIO);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

   if (RATIO < 2 || TIMEOUT < 1 || OUT_WIDTH != IN_WIDTH * RATIO) begin : g_bad_cfg
      $error("fifo_rd_packer: invalid parameter set");
   end

   logic [RATIO-1:0][IN_WIDTH-1:0] acc_q, acc_d, acc_w;
   logic [IDX_W-1:0]               idx_q, idx_d;
   logic                           fp_q, fp_d;
   logic [OUT_WIDTH-1:0]           data_q, data_d;
   logic [RATIO-1:0]               keep_q, keep_d;
   logic                           last_q, last_d;
   logic                           valid_q, valid_d;

   logic                           slot_free;
   logic                           pop;
   logic                           flush_req;
   logic                           load;
   logic [RATIO-1:0][IN_WIDTH-1:0] word_data;
   logic [RATIO-1:0]               word_keep;
   logic                           word_last;

   assign slot_free    = !valid_q || bus.m_ready;
   assign pop          = !rst && !bus.fifo_empty && !fp_q && (idx_q < IDX_FULL);
   assign bus.fifo_ren = pop;

`ifdef PACKER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] idle_q, idle_d;
   logic             to_hit;

   assign to_hit    = (idx_q != '0) && bus.fifo_empty && !fp_q && (idle_q == CNT_W'(TIMEOUT - 1));
   assign flush_req = bus.flush || to_hit;

   always_comb begin
      idle_d = idle_q;
      if (pop || fp_q || fp_d || idx_q == '0) begin
         idle_d = '0;
      end else if (bus.fifo_empty) begin
         idle_d = idle_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   assign flush_req = bus.flush;
`endif

   always_comb begin
      acc_w = acc_q;
      if (pop) begin
         acc_w[idx_q[LANE_W-1:0]] = bus.fifo_rdata;
      end
   end

   // Priority: pending flush, then a held full word, then a pop (possibly closing the word).
   always_comb begin
      acc_d     = acc_w;
      idx_d     = idx_q;
      fp_d      = fp_q;
      load      = 1'b0;
      word_data = acc_w;
      word_keep = '1;
      word_last = flush_req;
      if (fp_q) begin
         if (slot_free) begin
            load      = 1'b1;
            word_last = 1'b1;
            idx_d     = '0;
            fp_d      = 1'b0;
            for (int unsigned i = 0; i < RATIO; i++) begin
               if (i >= 32'(idx_q)) begin
                  word_data[i] = '0;
                  word_keep[i] = 1'b0;
               end
            end
         end
      end else if (idx_q == IDX_FULL) begin
         if (slot_free) begin
            load  = 1'b1;
            idx_d = '0;
         end
      end else if (pop) begin
         if (idx_q == IDX_LAST && slot_free) begin
            load  = 1'b1;
            idx_d = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
            fp_d  = flush_req && (idx_q != IDX_LAST);
         end
      end else if (flush_req && idx_q != '0) begin
         fp_d = 1'b1;
      end
   end

   always_comb begin
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      valid_d = valid_q;
      if (load) begin
         data_d  = word_data;
         keep_d  = word_keep;
         last_d  = word_last;
         valid_d = 1'b1;
      end else if (bus.m_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= '0;
         idx_q   <= '0;
         fp_q    <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         fp_q    <= fp_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

   assign bus.m_valid = valid_q;
   assign bus.m_data  = data_q;
   assign bus.m_keep  = keep_q;
   assign bus.m_last  = last_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: directed cases plus a random phase against a
// byte-queue model (entries popped in order, closed into words on RATIO entries or a flush).
module tb_fifo_rd_packer;
   localparam int unsigned IN_WIDTH = 8;
   localparam int unsigned RATIO    = 4;
   localparam int unsigned TIMEOUT  = 16;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_rd_packer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) bus ();

   fifo_rd_packer #(
      .IN_WIDTH(IN_WIDTH),
      .RATIO   (RATIO),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [7:0]  fifo_q[$];
   logic [7:0]  part[$];
   word_t       exp_q[$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic        pop_now = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic [3:0]  prev_keep;
   logic        prev_last;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic drive_fifo();
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   endtask

   task automatic model_close(input logic last);
      word_t w;
      w.data = '0;
      foreach (part[i]) w.data[i*8 +: 8] = part[i];
      w.keep = 4'((1 << part.size()) - 1);
      w.last = last;
      exp_q.push_back(w);
      part.delete();
   endtask

   task automatic monitor();
      word_t w;
      if (rst) begin
         prev_stall = 1'b0;
         pop_now    = 1'b0;
         return;
      end
      check("ren_while_empty", 64'(bus.fifo_ren & bus.fifo_empty), 64'd0);
      if (prev_stall) begin
         check("hold_valid", 64'(bus.m_valid), 64'd1);
         check("hold_data", 64'(bus.m_data), 64'(prev_data));
         check("hold_keep", 64'(bus.m_keep), 64'(prev_keep));
         check("hold_last", 64'(bus.m_last), 64'(prev_last));
      end
      if (bus.m_valid && bus.m_ready) begin
         check("word_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("word_data", 64'(bus.m_data), 64'(w.data));
            check("word_keep", 64'(bus.m_keep), 64'(w.keep));
            check("word_last", 64'(bus.m_last), 64'(w.last));
         end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_keep  = bus.m_keep;
      prev_last  = bus.m_last;
      pop_now    = bus.fifo_ren;
      if (bus.fifo_ren) part.push_back(bus.fifo_rdata);
      if (part.size() == RATIO) model_close(bus.flush);
      else if (bus.flush && part.size() != 0) model_close(1'b1);
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      if (pop_now) void'(fifo_q.pop_front());
      pop_now = 1'b0;
      drive_fifo();
   endtask

   task automatic wait_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
      int n = 0;
      while (!bus.m_valid && n < 40) begin
         step();
         n++;
      end
      check({tag, "_seen"}, 64'(bus.m_valid), 64'd1);
      if (bus.m_valid) begin
         check({tag, "_data"}, 64'(bus.m_data), 64'(d));
         check({tag, "_keep"}, 64'(bus.m_keep), 64'(k));
         check({tag, "_last"}, 64'(bus.m_last), 64'(l));
      end
      bus.m_ready = 1'b1;
      step();
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      drive_fifo();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int n;
      int empty_run;
      logic rdy_prev;

      bus.m_ready = 1'b1;
      bus.flush   = 1'b0;
      drive_fifo();

      // Basic pack with reset release
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      step(); step();
      check("reset_valid", 64'(bus.m_valid), 64'd0);
      check("reset_ren", 64'(bus.fifo_ren), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t1_ren", 64'(bus.fifo_ren), 64'd1);
         step();
      end
      check("t1_valid", 64'(bus.m_valid), 64'd1);
      wait_word("t1", 32'h44332211, 4'hF, 1'b0);

      // Backpressure: two words, second held in the accumulator
      bus.m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push(8'(i));
      for (int i = 0; i < 10; i++) step();
      check("t2_ren_stall", 64'(bus.fifo_ren), 64'd0);
      check("t2_hold_data", 64'(bus.m_data), 64'h04030201);
      bus.m_ready = 1'b1;
      wait_word("t2a", 32'h04030201, 4'hF, 1'b0);
      wait_word("t2b", 32'h08070605, 4'hF, 1'b0);

      // Partial flush, then flush with nothing accumulated
      push(8'hAA); push(8'hBB);
      step(); step(); step();
      bus.flush = 1'b1; step(); bus.flush = 1'b0;
      wait_word("t3", 32'h0000BBAA, 4'h3, 1'b1);
      bus.flush = 1'b1; step(); bus.flush = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check("t3_no_word", 64'(bus.m_valid), 64'd0);

      // Flush coincident with third pop
      push(8'h11); push(8'h22); push(8'h33);
      step(); step();
      bus.flush = 1'b1; step(); bus.flush = 1'b0;
      wait_word("t4", 32'h00332211, 4'h7, 1'b1);

      // Reset with pending word and partial accumulator
      bus.m_ready = 1'b0;
      for (int i = 1; i <= 6; i++) push(8'hC0 + 8'(i));
      for (int i = 0; i < 8; i++) step();
      check("t5_pre_valid", 64'(bus.m_valid), 64'd1);
      rst = 1'b1;
      #1;
      check("t5_rst_valid", 64'(bus.m_valid), 64'd0);
      check("t5_rst_data", 64'(bus.m_data), 64'd0);
      check("t5_rst_keep", 64'(bus.m_keep), 64'd0);
      check("t5_rst_last", 64'(bus.m_last), 64'd0);
      check("t5_rst_ren", 64'(bus.fifo_ren), 64'd0);
      fifo_q.delete(); part.delete(); exp_q.delete();
      pop_now = 1'b0;
      drive_fifo();
      step(); step();
      rst = 1'b0;
      bus.m_ready = 1'b1;
      push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
      wait_word("t5", 32'hD4D3D2D1, 4'hF, 1'b0);

      // Idle single entry
      push(8'h5A);
      step();
      check("t6_popped", 64'(part.size()), 64'd1);
`ifdef PACKER_TIMEOUT_EN
      model_close(1'b1);
      n = 0;
      while (!bus.m_valid && n < 40) begin
         step();
         n++;
      end
      check("t6_latency", 64'(n), 64'(TIMEOUT + 1));
      wait_word("t6", 32'h0000005A, 4'h1, 1'b1);
`else
      for (int i = 0; i < 40; i++) step();
      check("t6_no_word", 64'(bus.m_valid), 64'd0);
      bus.flush = 1'b1; step(); bus.flush = 1'b0;
      wait_word("t6", 32'h0000005A, 4'h1, 1'b1);
`endif

      // Random phase
      empty_run = 0;
      rdy_prev  = bus.m_ready;
      for (int c = 0; c < 800; c++) begin
         rdy_prev    = bus.m_ready;
         bus.m_ready = ($urandom_range(0, 3) != 0);
         bus.flush   = rdy_prev && bus.m_ready && ($urandom_range(0, 11) == 0);
         if (fifo_q.size() == 0) empty_run++;
         else empty_run = 0;
         if ($urandom_range(0, 1) == 1 || empty_run >= 2) begin
            push(8'($urandom));
            empty_run = 0;
         end
         step();
      end
      bus.flush   = 1'b0;
      bus.m_ready = 1'b1;
      step();
      n = 0;
      while (fifo_q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      bus.flush = 1'b1; step(); bus.flush = 1'b0;
      n = 0;
      while ((exp_q.size() != 0 || bus.m_valid) && n < 100) begin
         step();
         n++;
      end
      check("drain_words", 64'(exp_q.size()), 64'd0);
      check("drain_part", 64'(part.size()), 64'd0);
      check("drain_valid", 64'(bus.m_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the byte-wide synchronous FIFO.
- Pops entries through the FIFO's ren/rdata/empty interface. rdata is show-ahead: the head entry is valid whenever empty=0.
- Packs RATIO entries into one wide word and presents it on a valid/ready master stream with a one-word output register.
- Partial words are emitted on an explicit flush, marked by byte-lane keep and last.

Parameters:
- IN_WIDTH, 8, width of one FIFO entry.
- RATIO, 4, FIFO entries per output word (>=2).
- OUT_WIDTH, IN_WIDTH*RATIO, output data width (derived; do not override).
- TIMEOUT, 16, idle cycles before auto-flush (used only with PACKER_TIMEOUT_EN; >=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- fifo_ren  out  1  pop request to the upstream FIFO.
- fifo_rdata  in  IN_WIDTH  FIFO head entry (show-ahead).
- fifo_empty  in  1  FIFO empty flag.
- flush  in  1  request to emit the current partial word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  OUT_WIDTH  packed word; first popped entry in bits [IN_WIDTH-1:0].
- m_keep  out  RATIO  per-lane valid mask, contiguous from lane 0.
- m_last  out  1  word was closed by a flush (partial or full).

Behaviour:
- State: accumulator acc[RATIO lanes], lane counter idx (0..RATIO), flush_pend, output register {m_data, m_keep, m_last, m_valid}.
- Reset (asynchronous, active-high):
  - Clears idx, flush_pend, m_valid, m_data, m_keep and m_last to 0.
  - fifo_ren=0 while rst=1.
  - Reset mid-operation discards the partial accumulator and any unaccepted output word.
- slot_free = !m_valid || m_ready.
- Pop condition, combinational:
  - fifo_ren = !rst && !fifo_empty && !flush_pend && (idx<RATIO).
  - fifo_ren never asserts while fifo_empty=1.
- On a pop: acc lane idx <= fifo_rdata; idx <= idx+1.
- Full-word close: the pop fills lane RATIO-1.
  - If slot_free: the word (including the popped entry) loads the output register at the same edge, with m_keep all-ones and m_last=flush. idx <= 0.
  - Otherwise: idx <= RATIO and fifo_ren is held low until slot_free. The word then loads and idx <= 0.
- Latency: m_valid rises on the edge that pops the last lane, so data is visible on the next cycle. Steady-state throughput is 1 pop/cycle and 1 word per RATIO cycles when m_ready=1.
- Flush:
  - flush=1 with idx>0 or a pop in the same cycle sets flush_pend. The popped entry is included.
  - flush=1 with idx=0 and no pop is ignored; no empty word is ever emitted.
  - While flush_pend=1 and slot_free: load the output register with the idx lanes, m_keep=(1<<idx)-1, m_last=1, unused lanes of m_data=0. Then idx <= 0 and flush_pend <= 0.
  - Pops resume on the following cycle.
- Output hold: while m_valid=1 && m_ready=0, m_data, m_keep and m_last are stable.
  - m_valid falls only after acceptance, when no new word loads at that edge.
  - Back-to-back words are allowed when m_ready=1.
- Arithmetic: idx is $clog2(RATIO+1) bits and never wraps past RATIO.

Optional Feature:
- Macro: PACKER_TIMEOUT_EN.
- Defined:
  - An idle counter increments each cycle with idx>0, fifo_empty=1 and flush_pend=0.
  - It clears on any pop, on flush_pend being set, or when idx=0.
  - When the counter reaches TIMEOUT-1 it sets flush_pend, behaving exactly like an external flush (m_last=1).
- Undefined:
  - No counter logic is present and TIMEOUT is unused.
  - Partial words wait indefinitely for flush or for more data.

Test Plan:
- Reset, then FIFO preloaded with 0x11,0x22,0x33,0x44 and m_ready=1:
  - 4 consecutive pops.
  - m_valid=1 one cycle after the 4th pop, with m_data=0x44332211, m_keep=4'b1111, m_last=0.
- FIFO holding 8 entries 0x01..0x08 with m_ready=0 until cycle 10:
  - First word 0x04030201 is held stable.
  - Accumulator fills to 0x08070605 and fifo_ren stays 0.
  - Both words are delivered in order after m_ready rises.
- Pop 0xAA,0xBB, FIFO empty, then flush pulse:
  - m_data=0x0000BBAA, m_keep=4'b0011, m_last=1.
  - A subsequent flush with idx=0 produces no word.
- Flush asserted in the same cycle as popping the 3rd entry 0x33 after 0x11,0x22:
  - Word 0x00332211, m_keep=4'b0111, m_last=1.
- rst asserted after 2 pops with an unaccepted word pending:
  - All outputs 0 immediately.
  - Next 4 entries form a clean word with m_keep=4'b1111.
- With PACKER_TIMEOUT_EN and TIMEOUT=16, one entry 0x5A followed by FIFO empty:
  - Word 0x0000005A, m_keep=4'b0001, m_last=1 emitted after 16 idle cycles.
  - Without the macro, no word is emitted.
